// File: rtl/pc_redirect.sv
// Fetch-PC sequencer with ID-stage branch/jump redirect and one-cycle squash bubble.
// Optional redirect counter enabled by defining PC_REDIRECT_CNT_EN.
module pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        branch_sig,
  input  logic [5:0]  inst_op_ID,
  input  logic [15:0] imm_ID,
  input  logic [25:0] jidx_ID,
  input  logic [31:0] pc_plus4_ID,
  input  logic        stall_ID,
  output logic [31:0] pc_IF,
  output logic        valid_ID,
  output logic [1:0]  state_o
`ifdef PC_REDIRECT_CNT_EN
  ,
  output logic [15:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;

  logic        w_accept;
  logic [31:0] w_jmp_target;
  logic [31:0] w_br_target;
  logic [31:0] w_target;

  // A branch sitting in a squashed (bubble) ID slot must never redirect.
  assign w_accept     = branch_sig & ~stall_ID & r_valid;
  assign w_jmp_target = {pc_plus4_ID[31:28], jidx_ID, 2'b00};
  assign w_br_target  = pc_plus4_ID + {{14{imm_ID[15]}}, imm_ID, 2'b00};
  assign w_target     = (inst_op_ID == 6'd2) ? w_jmp_target : w_br_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
    end else if (stall_ID) begin
      r_state <= HOLD;
    end else if (w_accept) begin
      r_state <= SQUASH;
      r_pc    <= w_target;
      r_valid <= 1'b0;
    end else begin
      r_state <= RUN;
      r_pc    <= r_pc + 32'd4;
      r_valid <= 1'b1;
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 16'd0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign redirect_cnt = r_cnt;
`endif

  assign pc_IF    = r_pc;
  assign valid_ID = r_valid;
  assign state_o  = r_state;

endmodule

// File: tb/tb_pc_redirect.sv
// Testbench for pc_redirect: hand-computed vector table followed by randomized
// stimulus checked against a rule-level reference model.
module tb_pc_redirect;

  logic        clk;
  logic        reset;
  logic        branch_sig;
  logic [5:0]  inst_op_ID;
  logic [15:0] imm_ID;
  logic [25:0] jidx_ID;
  logic [31:0] pc_plus4_ID;
  logic        stall_ID;
  logic [31:0] pc_IF;
  logic        valid_ID;
  logic [1:0]  state_o;
`ifdef PC_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] mPc;
  logic        mValid;
  logic [1:0]  mState;
  logic [15:0] mCnt;

  typedef struct {
    logic        rst;
    logic        br;
    logic [5:0]  op;
    logic [15:0] imm;
    logic [25:0] jidx;
    logic [31:0] pcp4;
    logic        stall;
    logic [31:0] expPc;
    logic        expValid;
    logic [1:0]  expState;
  } vec_t;

  vec_t vecs[24];

  pc_redirect #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .branch_sig  (branch_sig),
    .inst_op_ID  (inst_op_ID),
    .imm_ID      (imm_ID),
    .jidx_ID     (jidx_ID),
    .pc_plus4_ID (pc_plus4_ID),
    .stall_ID    (stall_ID),
    .pc_IF       (pc_IF),
    .valid_ID    (valid_ID),
    .state_o     (state_o)
`ifdef PC_REDIRECT_CNT_EN
    ,
    .redirect_cnt(redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic br, logic [5:0] op, logic [15:0] imm,
                              logic [25:0] jidx, logic [31:0] pcp4, logic stall,
                              logic [31:0] ePc, logic eValid, logic [1:0] eState);
    vec_t v;
    v.rst = rst; v.br = br; v.op = op; v.imm = imm; v.jidx = jidx;
    v.pcp4 = pcp4; v.stall = stall;
    v.expPc = ePc; v.expValid = eValid; v.expState = eState;
    return v;
  endfunction

  // Reference behaviour: what one clock edge does, stated directly from the rules.
  task automatic modelEdge();
    logic [31:0] offset;
    if (reset) begin
      mPc = 32'h0; mValid = 1'b0; mState = 2'd0; mCnt = 16'd0;
    end else if (stall_ID) begin
      mState = 2'd1;
    end else if (branch_sig && mValid) begin
      offset = 32'($signed(imm_ID)) * 4;
      if (inst_op_ID == 6'd2)
        mPc = (pc_plus4_ID & 32'hF000_0000) | (32'(jidx_ID) << 2);
      else
        mPc = pc_plus4_ID + offset;
      mValid = 1'b0; mState = 2'd2; mCnt = mCnt + 16'd1;
    end else begin
      mPc = mPc + 32'd4; mValid = 1'b1; mState = 2'd0;
    end
  endtask

  task automatic applyStimulus(logic rst, logic br, logic [5:0] op, logic [15:0] imm,
                               logic [25:0] jidx, logic [31:0] pcp4, logic stall);
    reset = rst; branch_sig = br; inst_op_ID = op; imm_ID = imm;
    jidx_ID = jidx; pc_plus4_ID = pcp4; stall_ID = stall;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput(string name, int idx, logic [31:0] ePc, logic eValid, logic [1:0] eState);
    checks++;
    if (pc_IF !== ePc) begin
      errors++;
      $display("[TB] FAIL %s[%0d] pc_IF: got %h expected %h", name, idx, pc_IF, ePc);
    end
    checks++;
    if (valid_ID !== eValid) begin
      errors++;
      $display("[TB] FAIL %s[%0d] valid_ID: got %b expected %b", name, idx, valid_ID, eValid);
    end
    checks++;
    if (state_o !== eState) begin
      errors++;
      $display("[TB] FAIL %s[%0d] state_o: got %0d expected %0d", name, idx, state_o, eState);
    end
`ifdef PC_REDIRECT_CNT_EN
    checks++;
    if (redirect_cnt !== mCnt) begin
      errors++;
      $display("[TB] FAIL %s[%0d] redirect_cnt: got %h expected %h", name, idx, redirect_cnt, mCnt);
    end
`endif
  endtask

  initial begin
    mPc = 32'h0; mValid = 1'b0; mState = 2'd0; mCnt = 16'd0;
    reset = 1'b1; branch_sig = 1'b0; inst_op_ID = 6'd0; imm_ID = 16'd0;
    jidx_ID = 26'd0; pc_plus4_ID = 32'd0; stall_ID = 1'b0;

    // Hand-derived expectations: reset, idle counting, branch/jump, stall interplay, wrap.
    vecs[0]  = mk(1, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h0000_0000, 0, 2'd0);
    vecs[1]  = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h0000_0004, 1, 2'd0);
    vecs[2]  = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h0000_0008, 1, 2'd0);
    vecs[3]  = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h0000_000C, 1, 2'd0);
    vecs[4]  = mk(0, 1, 6'd4, 16'hFFFE, 26'h0,       32'h0000_0100, 0, 32'h0000_00F8, 0, 2'd2);
    vecs[5]  = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h0000_00FC, 1, 2'd0);
    vecs[6]  = mk(0, 1, 6'd2, 16'h0000, 26'h0000040, 32'h4000_0010, 0, 32'h4000_0100, 0, 2'd2);
    vecs[7]  = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h4000_0104, 1, 2'd0);
    vecs[8]  = mk(0, 1, 6'd4, 16'h0004, 26'h0,       32'h0000_0200, 1, 32'h4000_0104, 1, 2'd1);
    vecs[9]  = mk(0, 1, 6'd4, 16'h0004, 26'h0,       32'h0000_0200, 1, 32'h4000_0104, 1, 2'd1);
    vecs[10] = mk(0, 1, 6'd4, 16'h0004, 26'h0,       32'h0000_0200, 0, 32'h0000_0210, 0, 2'd2);
    vecs[11] = mk(0, 1, 6'd4, 16'h0004, 26'h0,       32'h0000_0200, 0, 32'h0000_0214, 1, 2'd0);
    vecs[12] = mk(1, 1, 6'd4, 16'h0004, 26'h0,       32'h0000_0200, 0, 32'h0000_0000, 0, 2'd0);
    vecs[13] = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 1, 32'h0000_0000, 0, 2'd1);
    vecs[14] = mk(0, 1, 6'd4, 16'h0010, 26'h0,       32'h0000_0800, 0, 32'h0000_0004, 1, 2'd0);
    vecs[15] = mk(0, 1, 6'd4, 16'h0001, 26'h0,       32'h0000_1000, 0, 32'h0000_1004, 0, 2'd2);
    vecs[16] = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 1, 32'h0000_1004, 0, 2'd1);
    vecs[17] = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h0000_1008, 1, 2'd0);
    vecs[18] = mk(1, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 1, 32'h0000_0000, 0, 2'd0);
    vecs[19] = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h0000_0004, 1, 2'd0);
    vecs[20] = mk(0, 1, 6'd2, 16'h0000, 26'h3FFFFFF, 32'hF000_0000, 0, 32'hFFFF_FFFC, 0, 2'd2);
    vecs[21] = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h0000_0000, 1, 2'd0);
    vecs[22] = mk(0, 1, 6'd5, 16'hFFFF, 26'h0,       32'h0000_0000, 0, 32'hFFFF_FFFC, 0, 2'd2);
    vecs[23] = mk(0, 0, 6'd0, 16'h0000, 26'h0,       32'h0000_0000, 0, 32'h0000_0000, 1, 2'd0);

    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].br, vecs[i].op, vecs[i].imm,
                    vecs[i].jidx, vecs[i].pcp4, vecs[i].stall);
      checkOutput("vec", i, vecs[i].expPc, vecs[i].expValid, vecs[i].expState);
    end

    // Multi-cycle: long stall during a pending branch, then release.
    applyStimulus(0, 0, 6'd0, 16'h0, 26'h0, 32'h0, 0);
    checkOutput("seq", 0, mPc, mValid, mState);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 6'd2, 16'h0, 26'h0123456, 32'h8000_0000, 1);
      checkOutput("seq", i, mPc, mValid, mState);
    end
    applyStimulus(0, 1, 6'd2, 16'h0, 26'h0123456, 32'h8000_0000, 0);
    checkOutput("seqJump", 5, 32'h8048_D158, 1'b0, 2'd2);

    // Randomized stimulus against the reference model.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 31) == 0),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? 6'd2 : 6'($urandom),
                    16'($urandom), 26'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0));
      checkOutput("rand", i, mPc, mValid, mState);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_redirect.md
PC_REDIRECT -- requirements
Module: pc_redirect

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 branch_sig  input  1  redirect request from the ID-stage branch decision (beq taken, bne taken, j).
REQ-005 inst_op_ID  input  6  opcode of the instruction in ID; 6'd2 = j, otherwise PC-relative branch.
REQ-006 imm_ID  input  16  branch offset field of the instruction in ID, in words.
REQ-007 jidx_ID  input  26  jump index field of the instruction in ID.
REQ-008 pc_plus4_ID  input  32  PC+4 of the instruction in ID.
REQ-009 stall_ID  input  1  hazard-unit stall; holds PC and the ID stage.
REQ-010 pc_IF  output  32  registered fetch address.
REQ-011 valid_ID  output  1  registered; 1 = the instruction now entering ID is real, 0 = bubble.
REQ-012 state_o  output  2  current FSM state: 0 RUN, 1 HOLD, 2 SQUASH.

Function
REQ-013 States: RUN (normal fetch), HOLD (stalled), SQUASH (one-cycle bubble after a redirect).
REQ-014 A redirect is accepted only when branch_sig=1, stall_ID=0 and valid_ID=1; branch_sig is ignored while valid_ID=0.
REQ-015 Jump target: {pc_plus4_ID[31:28], jidx_ID, 2'b00}.
REQ-016 Branch target: pc_plus4_ID + ({{14{imm_ID[15]}}, imm_ID, 2'b00}), modulo 2^32.
REQ-017 Sequential PC increment: pc_IF + 4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-018 On an accepted redirect, pc_IF takes the target at the next edge; valid_ID = 0 for exactly one cycle; state moves to SQUASH.
REQ-019 In SQUASH: pc_IF increments; valid_ID returns to 1 at the next edge; state moves to RUN, or to HOLD if stall_ID=1.
REQ-020 stall_ID=1 from any state: pc_IF and valid_ID hold; state moves to HOLD.
REQ-021 stall_ID and branch_sig both 1: the stall wins; no redirect; the branch is re-evaluated when the stall clears.
REQ-022 In HOLD with stall_ID=0: resume RUN behaviour in the same cycle, including acceptance of a pending redirect.
REQ-023 In RUN with no stall and no redirect: pc_IF increments; valid_ID = 1.
REQ-024 Latency: target visible on pc_IF exactly one clock after the accepting edge; no combinational path from any input to any output.

Reset
REQ-025 When reset=1 at an edge: pc_IF = RESET_PC, valid_ID = 0, state = RUN, counter (if built) = 0; all other inputs are ignored.
REQ-026 Reset asserted mid-redirect or mid-stall overrides everything; the first cycle after release fetches RESET_PC+4 and sets valid_ID = 1.

Configuration
REQ-027 Macro PC_REDIRECT_CNT_EN defined: adds output redirect_cnt (16 bits), incremented on each accepted redirect and wrapping 16'hFFFF -> 16'h0000, cleared by reset.
REQ-028 Macro PC_REDIRECT_CNT_EN undefined: no redirect_cnt port and no counter logic; all other behaviour is identical.

Verification
REQ-029 Reset with RESET_PC=0, then 3 idle cycles -> pc_IF 0, 4, 8, 12; valid_ID 0 then 1.
REQ-030 pc_plus4_ID=0x100, imm_ID=16'hFFFE, op=4, branch_sig=1 -> next pc_IF=0xF8; valid_ID=0 for one cycle; state_o sequence 2 then 0.
REQ-031 pc_plus4_ID=0x4000_0010, jidx_ID=26'h0000040, op=2 -> next pc_IF=0x4000_0100.
REQ-032 branch_sig=1 together with stall_ID=1 for 2 cycles -> pc_IF held and state_o=1; redirect taken on the edge after the stall clears.
REQ-033 Two consecutive branch_sig cycles -> second ignored (valid_ID=0); redirect_cnt increments by 1 only.
REQ-034 pc_IF=0xFFFF_FFFC, idle -> pc_IF=0; redirect_cnt preset via 65535 redirects -> wraps to 0.
